// File: rtl/idecode_queue_if.sv
// Fetch-to-controller handshake bundle for idecode_queue: raw instruction in, decoded head entry out.
// DATA_W and DEPTH must match the idecode_queue instance the bundle is attached to.
interface idecode_queue_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_ir;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        opcode;
  logic [1:0]        ALU_op;
  logic [1:0]        shift_op;
  logic [2:0]        rn;
  logic [2:0]        rd;
  logic [2:0]        rm;
  logic [DATA_W-1:0] sximm5;
  logic [DATA_W-1:0] sximm8;
  logic [CNT_W-1:0]  count;

  // Fetch/controller side.
  modport master (
    output flush, in_valid, in_ir, out_ready,
    input  in_ready, out_valid, opcode, ALU_op, shift_op, rn, rd, rm, sximm5, sximm8, count
  );

  // Queue side.
  modport slave (
    input  flush, in_valid, in_ir, out_ready,
    output in_ready, out_valid, opcode, ALU_op, shift_op, rn, rd, rm, sximm5, sximm8, count
  );
endinterface

// File: rtl/idecode_queue.sv
// DEPTH-entry instruction FIFO presenting its head entry fully decoded; one-cycle push-to-output
// latency with no bypass, full queue accepts when the head is popped the same cycle, flush drops all.
module idecode_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  idecode_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;
  logic [15:0]   w_ir;

  assign w_out_valid   = (r_count != '0);
  assign bus.out_valid = w_out_valid;
  assign bus.in_ready  = ~bus.flush & ((r_count < CW'(DEPTH)) | bus.out_ready);
  assign bus.count     = r_count;

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = w_out_valid & bus.out_ready;

  // Storage carries no reset; only the pointers and occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_ir;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_ir = r_mem[r_rd_ptr];

  // Fields are held at zero while empty so the controller never sees a stale head.
  always_comb begin
    bus.opcode   = '0;
    bus.ALU_op   = '0;
    bus.shift_op = '0;
    bus.rn       = '0;
    bus.rd       = '0;
    bus.rm       = '0;
    bus.sximm5   = '0;
    bus.sximm8   = '0;
    if (w_out_valid) begin
      bus.opcode   = w_ir[15:13];
      bus.ALU_op   = w_ir[12:11];
      bus.shift_op = w_ir[4:3];
      bus.rn       = w_ir[10:8];
      bus.rd       = w_ir[7:5];
      bus.rm       = w_ir[2:0];
      bus.sximm5   = {{(DATA_W-5){w_ir[4]}}, w_ir[4:0]};
      bus.sximm8   = {{(DATA_W-8){w_ir[7]}}, w_ir[7:0]};
    end
  end
endmodule

// File: tb/tb_idecode_queue.sv
// Directed bench for idecode_queue: a 16-bit queue tracked by a scoreboard every cycle,
// plus a 32-bit instance for wide sign extension.
module tb_idecode_queue;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  idecode_queue_if #(.DATA_W(16), .DEPTH(4)) a_if ();
  idecode_queue_if #(.DATA_W(32), .DEPTH(4)) b_if ();

  idecode_queue #(.DATA_W(16), .DEPTH(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  idecode_queue #(.DATA_W(32), .DEPTH(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  function automatic logic [47:0] dec(input logic [15:0] ir);
    logic signed [15:0] s5;
    logic signed [15:0] s8;
    s5 = $signed(ir[4:0]);
    s8 = $signed(ir[7:0]);
    return {ir[15:13], ir[12:11], ir[4:3], ir[10:8], ir[7:5], ir[2:0], s5, s8};
  endfunction

  function automatic logic [47:0] obs_a();
    return {a_if.opcode, a_if.ALU_op, a_if.shift_op, a_if.rn, a_if.rd, a_if.rm,
            a_if.sximm5, a_if.sximm8};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check queue A against the scoreboard mid-cycle, update the scoreboard, then step one clock.
  task automatic cycle();
    logic exp_rdy;
    logic push;
    logic pop;
    @(negedge clk);
    if (rst_n) begin
      exp_rdy = !a_if.flush && ((sb.size() < 4) || a_if.out_ready);
      chk("in_ready", 64'(a_if.in_ready), 64'(exp_rdy));
      chk("count", 64'(a_if.count), 64'(sb.size()));
      chk("out_valid", 64'(a_if.out_valid), 64'(sb.size() != 0));
      chk("head", 64'(obs_a()), (sb.size() != 0) ? 64'(dec(sb[0])) : 64'h0);
      push = a_if.in_valid && exp_rdy;
      pop  = a_if.out_ready && (sb.size() != 0);
      if (a_if.flush) begin
        sb.delete();
      end else begin
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back(a_if.in_ir);
      end
    end else begin
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    a_if.flush     = 1'b0;
    a_if.in_valid  = 1'b0;
    a_if.in_ir     = '0;
    a_if.out_ready = 1'b0;
    b_if.flush     = 1'b0;
    b_if.in_valid  = 1'b0;
    b_if.in_ir     = '0;
    b_if.out_ready = 1'b0;

    // T1 reset
    cycle();
    cycle();
    rst_n = 1'b1;
    chk("rst_count", 64'(a_if.count), 64'd0);
    chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
    chk("rst_fields", 64'(obs_a()), 64'd0);
    chk("rst_in_ready", 64'(a_if.in_ready), 64'd1);
    chk("rst_b_in_ready", 64'(b_if.in_ready), 64'd1);

    // T2 decode
    a_if.in_valid = 1'b1;
    a_if.in_ir    = 16'hAA75;
    cycle();
    a_if.in_valid = 1'b0;
    chk("t2_out_valid", 64'(a_if.out_valid), 64'd1);
    chk("t2_opcode", 64'(a_if.opcode), 64'd5);
    chk("t2_ALU_op", 64'(a_if.ALU_op), 64'd1);
    chk("t2_rn", 64'(a_if.rn), 64'd2);
    chk("t2_rd", 64'(a_if.rd), 64'd3);
    chk("t2_rm", 64'(a_if.rm), 64'd5);
    chk("t2_shift_op", 64'(a_if.shift_op), 64'd2);
    chk("t2_sximm5", 64'(a_if.sximm5), 64'hFFF5);
    chk("t2_sximm8", 64'(a_if.sximm8), 64'h0075);
    a_if.out_ready = 1'b1;
    cycle();
    a_if.out_ready = 1'b0;

    // T3 sign extension at DATA_W=32
    b_if.in_valid = 1'b1;
    b_if.in_ir    = 16'h6080;
    cycle();
    b_if.in_valid = 1'b0;
    chk("t3_out_valid", 64'(b_if.out_valid), 64'd1);
    chk("t3_sximm8", 64'(b_if.sximm8), 64'hFFFF_FF80);
    chk("t3_sximm5", 64'(b_if.sximm5), 64'd0);
    chk("t3_opcode", 64'(b_if.opcode), 64'd3);
    chk("t3_rn", 64'(b_if.rn), 64'd0);

    // T4 fill past capacity, then stream through a full queue across pointer wrap
    for (int i = 0; i < 5; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_ir    = 16'($urandom);
      cycle();
    end
    chk("t4_full_in_ready", 64'(a_if.in_ready), 64'd0);
    chk("t4_full_count", 64'(a_if.count), 64'd4);
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_if.in_ir = 16'($urandom);
      cycle();
      chk("t4_stream_count", 64'(a_if.count), 64'd4);
    end
    a_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    a_if.out_ready = 1'b0;
    chk("t4_drained", 64'(a_if.count), 64'd0);

    // T5 flush with a concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_ir    = 16'($urandom);
      cycle();
    end
    a_if.flush     = 1'b1;
    a_if.in_ir     = 16'hBEEF;
    a_if.out_ready = 1'b1;
    cycle();
    a_if.flush     = 1'b0;
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b0;
    chk("t5_count", 64'(a_if.count), 64'd0);
    chk("t5_out_valid", 64'(a_if.out_valid), 64'd0);
    a_if.in_valid = 1'b1;
    a_if.in_ir    = 16'h1D2C;
    cycle();
    a_if.in_valid = 1'b0;
    chk("t5_new_head", 64'(obs_a()), 64'(dec(16'h1D2C)));
    a_if.out_ready = 1'b1;
    cycle();
    a_if.out_ready = 1'b0;

    // T6 reset mid-stream
    for (int i = 0; i < 2; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_ir    = 16'($urandom);
      cycle();
    end
    a_if.in_valid = 1'b0;
    chk("t6_pre_count", 64'(a_if.count), 64'd2);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_count", 64'(a_if.count), 64'd0);
    chk("t6_out_valid", 64'(a_if.out_valid), 64'd0);
    a_if.in_valid = 1'b1;
    a_if.in_ir    = 16'h8F13;
    cycle();
    a_if.in_ir    = 16'h7E04;
    cycle();
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    chk("t6_first_new", 64'(obs_a()), 64'(dec(16'h8F13)));
    cycle();
    chk("t6_second_new", 64'(obs_a()), 64'(dec(16'h7E04)));
    cycle();
    cycle();
    a_if.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
